instr_encoder: RTL and testbench

Streaming RV32I instruction encoder. It is the inverse of the core's field decoder: it takes decoded fields (type, opcode, funct3/funct7, register IDs, full immediate) and packs them into raw 32-bit instruction words. Each word is tagged with a sequential instruction-memory address. Used by the debug/boot loader and by testbenches to build programs for instruction memory. Includes an output FIFO with valid/ready backpressure and immediate range checking.

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into raw instruction words,
// tags each word with a sequential address and queues it in a small FIFO.
// Inputs with an out-of-range, misaligned or illegal-type immediate are
// consumed but not queued; they raise a one-cycle error pulse instead.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3, T_U = 3'd4, T_UJ = 3'd5
  } itype_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic signed [31:0] imm_s;
  logic [31:0]        enc;
  logic [1:0]         err_c;
  logic               accept, push, pop, full;

  entry_t             mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        occ;
  logic [ADDR_W-1:0]  next_addr;

  assign imm_s = $signed(in_imm);

  // Field packing and immediate legality; range errors win over alignment.
  always_comb begin
    enc   = '0;
    err_c = 2'd0;
    case (in_type)
      T_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      T_I: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) err_c = 2'd1;
      end
      T_S: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) err_c = 2'd1;
      end
      T_SB: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], in_opcode};
        if (imm_s < -32'sd4096 || imm_s > 32'sd4094) err_c = 2'd1;
        else if (in_imm[0])                          err_c = 2'd2;
      end
      T_U: begin
        enc = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != 12'd0) err_c = 2'd2;
      end
      T_UJ: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) err_c = 2'd1;
        else if (in_imm[0])                                err_c = 2'd2;
      end
      default: err_c = 2'd3;
    endcase
  end

  // Ready comes only from occupancy, so a same-cycle pop never frees a slot.
  assign full      = (occ == (PW+1)'(DEPTH));
  assign in_ready  = ~full;
  assign out_valid = (occ != '0);
  assign accept    = in_valid & in_ready & ~clear;
  assign push      = accept & (err_c == 2'd0);
  assign pop       = out_valid & out_ready & ~clear;

  // Head is gated so an empty FIFO shows the reset values.
  assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
  assign out_addr  = out_valid ? mem[rd_ptr].addr  : BASE_ADDR;

  // FIFO storage; the tag is the address counter value at push time.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: enc, addr: next_addr};
  end

  // Pointers, occupancy, address counter and emitted-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      next_addr <= BASE_ADDR;
      count     <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      next_addr <= BASE_ADDR;
      count     <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        next_addr <= next_addr + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        count  <= count + 16'd1;
      end
      if (push && !pop)      occ <= occ + (PW+1)'(1);
      else if (pop && !push) occ <= occ - (PW+1)'(1);
    end
  end

  // Error pulse one cycle after a rejected input; the code is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else if (clear) begin
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= accept && (err_c != 2'd0);
      if (accept && (err_c != 2'd0)) err_code <= err_c;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver predicts each accepted
// input (word+address or error code) into queues, and a negedge monitor
// compares them against what the DUT presents.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam int          AW    = 32;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk, rst, clear, in_valid, in_ready, out_valid, out_ready, err_valid;
  logic [2:0]  in_type, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm, out_instr;
  logic [AW-1:0] out_addr;
  logic [1:0]  err_code;
  logic [15:0] count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_valid(err_valid), .err_code(err_code), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          err_q[$];
  logic [31:0] model_addr = BASE;
  logic [15:0] model_count = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: bit positions of each format built from shifted fields.
  function automatic logic [31:0] model_enc(int typ, int op, int f3, int f7,
                                            int rs1, int rs2, int rd, int imm);
    logic [31:0] u = imm;
    logic [31:0] regs = (rs1 << 15) + (f3 << 12) + op;
    case (typ)
      0: return (f7 << 25) + (rs2 << 20) + regs + (rd << 7);
      1: return ((u & 32'hfff) << 20) + regs + (rd << 7);
      2: return (((u >> 5) & 32'h7f) << 25) + (rs2 << 20) + regs + ((u & 32'h1f) << 7);
      3: return (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3f) << 25) + (rs2 << 20) + regs
              + (((u >> 1) & 32'hf) << 8) + (((u >> 11) & 1) << 7);
      4: return (u & 32'hfffff000) + (rd << 7) + op;
      5: return (((u >> 20) & 1) << 31) + (((u >> 1) & 32'h3ff) << 21) + (((u >> 11) & 1) << 20)
              + (((u >> 12) & 32'hff) << 12) + (rd << 7) + op;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_err(int typ, int imm);
    case (typ)
      0:       return 0;
      1, 2:    return (imm < -2048 || imm > 2047) ? 1 : 0;
      3:       return (imm < -4096 || imm > 4094) ? 1 : ((imm % 2 != 0) ? 2 : 0);
      4:       return ((imm & 32'hfff) != 0) ? 2 : 0;
      5:       return (imm < -1048576 || imm > 1048574) ? 1 : ((imm % 2 != 0) ? 2 : 0);
      default: return 3;
    endcase
  endfunction

  task automatic flush_model();
    exp_q.delete();
    err_q.delete();
    model_addr  = BASE;
    model_count = 0;
  endtask

  // Present one input until accepted, then record the prediction.
  task automatic send(input int typ, input int op, input int f3, input int f7,
                      input int rs1, input int rs2, input int rd, input int imm,
                      input bit use_exp = 0, input int exp_code = 0,
                      input logic [31:0] exp_w = 0);
    int n = 0;
    int code;
    logic [31:0] w;
    in_type = 3'(typ); in_opcode = 7'(op); in_funct3 = 3'(f3); in_funct7 = 7'(f7);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_imm = imm;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(n), 64'(0));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    code = use_exp ? exp_code : model_err(typ, imm);
    w    = use_exp ? exp_w : model_enc(typ, op, f3, f7, rs1, rs2, rd, imm);
    if (code != 0) err_q.push_back(code);
    else begin
      exp_q.push_back({w, model_addr});
      model_addr += 4;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 || err_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: occupancy-derived handshakes, error pulses and popped words.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en || rst || clear) continue;
      chk("count", 64'(count), 64'(model_count));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (err_valid) begin
        if (err_q.size() == 0) chk("spurious_err", 64'(err_valid), 64'(0));
        else chk("err_code", 64'(err_code), 64'(err_q.pop_front()));
      end else if (err_q.size() != 0) begin
        chk("missing_err", 64'(err_valid), 64'(1));
        void'(err_q.pop_front());
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_instr", 64'(out_instr), 64'(e[63:32]));
        chk("out_addr", 64'(out_addr), 64'(e[31:0]));
        model_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                  1048574, 1048576, -1048576, -1048578, 1048575};

  initial begin
    int typ, imm, sel;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(BASE));
    chk("rst_err", 64'({err_valid, err_code}), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    // Directed encodings and immediate checks
    out_ready = 1'b1;
    send(1, 'h13, 0, 0, 0, 0, 1, 5, 1, 0, 32'h00500093);
    send(0, 'h33, 0, 0, 1, 2, 3, 0, 1, 0, 32'h002081B3);
    send(2, 'h23, 2, 0, 1, 2, 0, 8, 1, 0, 32'h0020A423);
    send(3, 'h63, 0, 0, 1, 2, 0, -4, 1, 0, 32'hFE208EE3);
    send(5, 'h6F, 0, 0, 0, 0, 1, 2048, 1, 0, 32'h001000EF);
    send(1, 'h13, 0, 0, 0, 0, 1, 4096, 1, 1);
    send(1, 'h13, 0, 0, 0, 0, 2, -2048);
    send(3, 'h63, 1, 0, 3, 4, 0, 6);
    send(3, 'h63, 1, 0, 3, 4, 0, 5, 1, 2);
    send(6, 'h13, 0, 0, 0, 0, 1, 0, 1, 3);
    send(3, 'h63, 0, 0, 1, 1, 0, 4095, 1, 1);
    send(4, 'h37, 0, 0, 0, 0, 5, 32'h12345001, 1, 2);
    send(4, 'h37, 0, 0, 0, 0, 5, 32'h12345000, 1, 0, 32'h123452B7);
    send(5, 'h6F, 0, 0, 0, 0, 1, 1048576, 1, 1);
    send(2, 'h23, 0, 0, 7, 9, 0, 2047);
    drain();

    // Fill to DEPTH with the consumer stalled, then drain in order
    out_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_model();
    for (int i = 0; i < DEPTH; i++) send(1, 'h13, 0, 0, i, 0, i + 1, i);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    chk("drained_count", 64'(count), 64'(DEPTH));
    @(posedge clk); #1;

    // Async reset with words queued
    out_ready = 1'b0;
    send(0, 'h33, 0, 0, 1, 2, 3, 0);
    send(0, 'h33, 0, 0, 4, 5, 6, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    flush_model();
    @(posedge clk); #1;
    rst = 1'b0;
    send(1, 'h13, 0, 0, 0, 0, 7, 1);
    drain();

    // Synchronous clear with words queued
    out_ready = 1'b0;
    send(0, 'h33, 0, 0, 1, 2, 3, 0);
    send(0, 'h33, 0, 0, 4, 5, 6, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_model();
    chk("clear_out_valid", 64'(out_valid), 64'(0));
    chk("clear_count", 64'(count), 64'(0));
    send(1, 'h13, 0, 0, 0, 0, 7, 1);
    drain();

    // Randomized traffic with random consumer stalls
    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      typ = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      sel = $urandom_range(0, 5);
      case (sel)
        0: imm = int'($urandom_range(0, 40)) - 20;
        1: imm = bnd[$urandom_range(0, 13)];
        2: imm = int'($urandom);
        3: imm = (int'($urandom_range(0, 5000)) - 2500) * 2;
        4: imm = int'($urandom & 32'hfffff000);
        default: imm = int'($urandom_range(0, 4194304)) - 2097152;
      endcase
      send(typ, int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
